// File: rtl/sl_rx_ctrl_if.sv
// CPU register port of the SL receiver controller: one-hot address, 1-cycle strobes,
// registered read data returned with a one-cycle valid pulse.
interface sl_rx_ctrl_if;
  logic [3:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (output addr, wr_en, rd_en, wdata, input rdata, rdata_valid);
  modport slave  (input addr, wr_en, rd_en, wdata, output rdata, rdata_valid);
endinterface

// File: rtl/sl_rx_ctrl.sv
// Host-side SL receiver controller: config ownership, received-word FIFO,
// sticky error flags, level/pulse interrupt and the CPU register port.
module sl_rx_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CFG_RESET  = 16'h0020
) (
  input  logic         clk,
  input  logic         rst,
  sl_rx_ctrl_if.slave  bus,
  input  logic [15:0]  rx_status_i,
  input  logic [31:0]  rx_data_i,
  output logic [15:0]  rx_config_o,
  output logic         irq_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] A_CFG = 4'b0001, A_DRD = 4'b0100, A_STS = 4'b1000;

  typedef enum logic {IDLE, PULSE} irq_st_e;

  // sticky bit order: 0 OVF, 1 PERR, 2 LERR, 3 VERR, 4 UDF, 5 CERR
  logic [15:0]   stat_q, cfg_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    sticky_q, sticky_d, sticky_set;
  logic [31:0]   rdata_q, rd_val;
  logic          rvld_q;
  irq_st_e       st_q, st_d;
  logic          irq_q, irq_d;

  logic wrf_ev, lef_ev, push_req, pop_req, do_push, do_pop, empty, full;
  logic cfg_wr, cfg_ok, sts_rd, mode_chg, evt;
  logic [3:0] cnt4;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign wrf_ev   = rx_status_i[3] & ~stat_q[3];
  assign lef_ev   = rx_status_i[5] & ~stat_q[5];
  assign push_req = wrf_ev & ~rx_status_i[4] & ~rx_status_i[0];
  assign pop_req  = bus.rd_en & (bus.addr == A_DRD);
  assign do_pop   = pop_req & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign do_push  = push_req & (~full | do_pop);
  assign sts_rd   = bus.rd_en & (bus.addr == A_STS);
  assign cfg_wr   = bus.wr_en & (bus.addr == A_CFG);
  assign cfg_ok   = cfg_wr & ~stat_q[1];
  assign mode_chg = cfg_ok & (bus.wdata[8] != cfg_q[8]);
  assign cnt4     = 4'(cnt_q);

  assign sticky_set = {cfg_wr & stat_q[1],
                       pop_req & empty,
                       lef_ev,
                       wrf_ev & rx_status_i[0],
                       wrf_ev & rx_status_i[4],
                       push_req & full & ~do_pop};
  assign sticky_d = (sts_rd ? 6'h0 : sticky_q) | sticky_set;
  assign evt      = do_push | (|sticky_set);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    rd_val = 32'h0;
    unique case (bus.addr)
      A_CFG:   rd_val = {16'h0, cfg_q};
      A_DRD:   rd_val = empty ? 32'h0 : mem_q[rp_q];
      A_STS:   rd_val = {19'h0, sticky_q[5], cnt4, sticky_q[4], stat_q[1],
                         sticky_q[3:0], full, empty};
      default: rd_val = 32'h0;
    endcase
  end

  always_comb begin
    st_d  = IDLE;
    irq_d = 1'b0;
    if (!mode_chg) begin
      if (cfg_q[8]) begin
        if (evt) st_d = PULSE;
        irq_d = (st_d == PULSE);
      end else begin
        irq_d = ~empty | (|sticky_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q   <= '0;
      cfg_q    <= CFG_RESET;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      rdata_q  <= '0;
      rvld_q   <= 1'b0;
      st_q     <= IDLE;
      irq_q    <= 1'b0;
    end else begin
      stat_q   <= rx_status_i;
      if (cfg_ok) cfg_q <= bus.wdata[15:0];
      if (do_push) wp_q <= wp_q + PW'(1);
      if (do_pop)  rp_q <= rp_q + PW'(1);
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      rvld_q   <= bus.rd_en;
      if (bus.rd_en) rdata_q <= rd_val;
      st_q     <= st_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= rx_data_i;
  end

  logic unused_bits;
  assign unused_bits = ^{stat_q[15:6], stat_q[4], stat_q[2], stat_q[0], bus.wdata[31:16], st_q};

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvld_q;
  assign rx_config_o     = cfg_q;
  assign irq_o           = irq_q;
endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Bench for sl_rx_ctrl: table of bus/receiver cycles with read results checked
// through a scoreboard, plus hand sequences for error, config-guard and irq cases.
module tb_sl_rx_ctrl;
  localparam logic [3:0] A_CFG = 4'b0001, A_DWR = 4'b0010, A_DRD = 4'b0100, A_STS = 4'b1000;

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [15:0] stat;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    int          id;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rx_status, rx_config;
  logic [31:0] rx_data;
  logic        irq;
  int          checks = 0, errors = 0, cyc = 0, rd_id = 0, irq_hi = 0;
  bit          irq_cnt_en = 0;
  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        tbl[$];

  sl_rx_ctrl_if bus ();

  sl_rx_ctrl #(.FIFO_DEPTH(4), .CFG_RESET(16'h0020)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rx_status_i(rx_status), .rx_data_i(rx_data),
    .rx_config_o(rx_config), .irq_o(irq)
  );

  always #31 clk = ~clk;
  always @(posedge clk) cyc++;

  // read scoreboard: each expected word must appear exactly one cycle after its strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        checks++; errors++;
        $display("FAIL read id=%0d no rdata_valid, required data=%h", mon_e.id, mon_e.exp);
      end
      if (bus.rdata_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious rdata_valid rdata=%h, required no valid", bus.rdata);
        end else begin
          mon_e = sb.pop_front();
          if (bus.rdata !== mon_e.exp || mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL read id=%0d rdata=%h at cyc %0d, required %h at cyc %0d",
                     mon_e.id, bus.rdata, cyc, mon_e.exp, mon_e.cyc);
          end
        end
      end
      if (irq_cnt_en && irq) irq_hi++;
    end
  end

  function automatic vec_t v(input logic [3:0] a, input logic w, input logic r,
                             input logic [31:0] wd, input logic [15:0] st,
                             input logic [31:0] d, input logic [31:0] e);
    vec_t t;
    t.addr = a; t.wr = w; t.rd = r; t.wdata = wd; t.stat = st; t.data = d; t.exp = e;
    return t;
  endfunction

  function automatic vec_t v_idle(input logic [15:0] st);
    return v(4'h0, 1'b0, 1'b0, 32'h0, st, 32'h0, 32'h0);
  endfunction

  function automatic vec_t v_rd(input logic [3:0] a, input logic [31:0] e, input logic [15:0] st);
    return v(a, 1'b0, 1'b1, 32'h0, st, 32'h0, e);
  endfunction

  function automatic vec_t v_wr(input logic [3:0] a, input logic [31:0] wd, input logic [15:0] st);
    return v(a, 1'b1, 1'b0, wd, st, 32'h0, 32'h0);
  endfunction

  task automatic drive(input vec_t t);
    @(negedge clk);
    bus.addr = t.addr; bus.wr_en = t.wr; bus.rd_en = t.rd; bus.wdata = t.wdata;
    rx_status = t.stat; rx_data = t.data;
    if (t.rd) begin
      sb.push_back('{t.exp, cyc + 1, rd_id});
      rd_id++;
    end
  endtask

  // WRF rising edge carrying a word, with extra status flags (PEF/WLC) alongside
  task automatic wrf(input logic [31:0] d, input logic [15:0] flags);
    drive(v(4'h0, 1'b0, 1'b0, 32'h0, 16'h0008 | flags, d, 32'h0));
    drive(v_idle(16'h0));
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, got, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.addr = '0; bus.wr_en = 0; bus.rd_en = 0; bus.wdata = '0;
    rx_status = '0; rx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rx_config", {16'h0, rx_config}, 32'h0000_0020);
    chk("reset irq", {31'h0, irq}, 32'h0);
    chk("reset rdata_valid", {31'h0, bus.rdata_valid}, 32'h0);
    rst = 1'b0;

    // capture, overflow, reserved/illegal addresses
    tbl.push_back(v_rd(A_STS, 32'h0000_0001, 16'h0));
    tbl.push_back(v_rd(A_CFG, 32'h0000_0020, 16'h0));
    tbl.push_back(v(4'h0, 1'b0, 1'b0, 32'h0, 16'h0008, 32'hDEAD_BEEF, 32'h0));
    tbl.push_back(v_idle(16'h0));
    tbl.push_back(v_rd(A_STS, 32'h0000_0100, 16'h0));
    tbl.push_back(v_rd(A_DRD, 32'hDEAD_BEEF, 16'h0));
    tbl.push_back(v_rd(A_STS, 32'h0000_0001, 16'h0));
    for (int i = 1; i <= 5; i++) begin
      tbl.push_back(v(4'h0, 1'b0, 1'b0, 32'h0, 16'h0008, 32'h1111_1111 * i, 32'h0));
      tbl.push_back(v_idle(16'h0));
    end
    tbl.push_back(v_rd(A_STS, 32'h0000_0406, 16'h0));
    for (int i = 1; i <= 4; i++) tbl.push_back(v_rd(A_DRD, 32'h1111_1111 * i, 16'h0));
    tbl.push_back(v_rd(A_STS, 32'h0000_0001, 16'h0));
    tbl.push_back(v_rd(A_DWR, 32'h0, 16'h0));
    tbl.push_back(v_wr(A_DWR, 32'hFFFF_FFFF, 16'h0));
    tbl.push_back(v_rd(4'b0011, 32'h0, 16'h0));
    tbl.push_back(v_rd(4'b0000, 32'h0, 16'h0));
    tbl.push_back(v_wr(4'b1001, 32'h0000_0041, 16'h0));
    tbl.push_back(v_rd(A_CFG, 32'h0000_0020, 16'h0));
    tbl.push_back(v_rd(A_STS, 32'h0000_0001, 16'h0));
    foreach (tbl[i]) drive(tbl[i]);

    // receiver errors: no pushes, each sets its own sticky flag
    wrf(32'hBAD0_0001, 16'h0010);
    wrf(32'hBAD0_0002, 16'h0001);
    drive(v_idle(16'h0020));
    drive(v_idle(16'h0));
    drive(v_rd(A_STS, 32'h0000_0039, 16'h0));
    drive(v_rd(A_DRD, 32'h0, 16'h0));
    drive(v_rd(A_STS, 32'h0000_0081, 16'h0));
    drive(v_rd(A_STS, 32'h0000_0001, 16'h0));

    // config write guarded by WRP
    drive(v_idle(16'h0002));
    drive(v_wr(A_CFG, 32'h0000_0041, 16'h0002));
    drive(v_idle(16'h0002));
    chk("cfg blocked by WRP", {16'h0, rx_config}, 32'h0000_0020);
    drive(v_rd(A_STS, 32'h0000_1041, 16'h0002));
    drive(v_idle(16'h0));
    drive(v_wr(A_CFG, 32'h0000_0041, 16'h0));
    drive(v_idle(16'h0));
    chk("cfg accepted", {16'h0, rx_config}, 32'h0000_0041);
    drive(v_rd(A_STS, 32'h0000_0001, 16'h0));
    drive(v_idle(16'h0));
    chk("level irq idle", {31'h0, irq}, 32'h0);

    // level irq: held until FIFO drained and the error flag read away
    wrf(32'hA5A5_0001, 16'h0);
    wrf(32'hA5A5_0002, 16'h0010);
    drive(v_idle(16'h0));
    chk("level irq data+err", {31'h0, irq}, 32'h1);
    drive(v_rd(A_DRD, 32'hA5A5_0001, 16'h0));
    drive(v_idle(16'h0));
    drive(v_idle(16'h0));
    chk("level irq err only", {31'h0, irq}, 32'h1);
    drive(v_rd(A_STS, 32'h0000_0009, 16'h0));
    drive(v_idle(16'h0));
    drive(v_idle(16'h0));
    chk("level irq cleared", {31'h0, irq}, 32'h0);

    // pulse irq: one pulse per push, push+pop on full keeps count
    drive(v_wr(A_CFG, 32'h0000_0141, 16'h0));
    drive(v_idle(16'h0));
    chk("cfg IRQM=1", {16'h0, rx_config}, 32'h0000_0141);
    chk("irq low after mode change", {31'h0, irq}, 32'h0);
    irq_hi = 0;
    irq_cnt_en = 1;
    for (int i = 1; i <= 4; i++) wrf(32'hB000_0000 + i, 16'h0);
    drive(v(A_DRD, 1'b0, 1'b1, 32'h0, 16'h0008, 32'hB000_0005, 32'hB000_0001));
    drive(v_idle(16'h0));
    drive(v_idle(16'h0));
    drive(v_rd(A_STS, 32'h0000_0402, 16'h0));
    for (int i = 2; i <= 5; i++) drive(v_rd(A_DRD, 32'hB000_0000 + i, 16'h0));
    drive(v_idle(16'h0));
    drive(v_idle(16'h0));
    irq_cnt_en = 0;
    chk("irq pulse cycles", irq_hi, 5);
    drive(v_wr(A_CFG, 32'h0000_0041, 16'h0));
    drive(v_idle(16'h0));
    chk("irq after back to level", {31'h0, irq}, 32'h0);

    // reset during a read strobe drops the read
    @(negedge clk);
    rst = 1'b1; bus.rd_en = 1'b1; bus.addr = A_STS;
    @(negedge clk);
    chk("reset drops read valid", {31'h0, bus.rdata_valid}, 32'h0);
    bus.rd_en = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
